// File: rtl/vga_pkg.sv
// Shared VGA geometry, colour constants and lane-renderer FSM states.
package vga_pkg;
  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int X_W      = 8;
  localparam int Y_W      = 7;
  localparam int COLOUR_W = 3;

  localparam logic [COLOUR_W-1:0] COLOUR_BLACK  = 3'b000;
  localparam logic [COLOUR_W-1:0] COLOUR_YELLOW = 3'b110;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ERASE = 2'd1,
    DRAW  = 2'd2,
    DONE  = 2'd3
  } lane_state_t;
endpackage

// File: rtl/rect_sweep_counter.sv
// Raster walker over a NOTE_W x NOTE_H footprint; dy carries the absolute 9-bit row.
module rect_sweep_counter #(
  parameter int NOTE_W = 8,
  parameter int NOTE_H = 4
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic [7:0] base_y,
  output logic [3:0] dx,
  output logic [8:0] dy,
  output logic       last,
  output logic       active
);
  localparam logic [3:0] COL_LAST = 4'(NOTE_W - 1);
  localparam logic [3:0] ROW_LAST = 4'(NOTE_H - 1);

  logic [3:0] row_off;

  assign last = active && (dx == COL_LAST) && (row_off == ROW_LAST);

  // start wins over the running sweep so the draw pass can chain directly onto erase
  always_ff @(posedge clk) begin
    if (!resetn) begin
      active  <= 1'b0;
      dx      <= '0;
      dy      <= '0;
      row_off <= '0;
    end else if (start) begin
      active  <= 1'b1;
      dx      <= '0;
      dy      <= {1'b0, base_y};
      row_off <= '0;
    end else if (active) begin
      if (dx == COL_LAST) begin
        dx <= '0;
        if (row_off == ROW_LAST) begin
          active <= 1'b0;
        end else begin
          row_off <= row_off + 4'd1;
          dy      <= dy + 9'd1;
        end
      end else begin
        dx <= dx + 4'd1;
      end
    end
  end
endmodule

// File: rtl/note_lane_renderer.sv
// One lane: per frame, erase the previous note rectangle then draw the new one.
module note_lane_renderer
  import vga_pkg::*;
#(
  parameter logic [X_W-1:0]      LANE_X      = 8'd20,
  parameter int                  NOTE_W      = 8,
  parameter int                  NOTE_H      = 4,
  parameter logic [COLOUR_W-1:0] NOTE_COLOUR = COLOUR_YELLOW,
  parameter logic [COLOUR_W-1:0] BG_COLOUR   = COLOUR_BLACK
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                frame_tick,
  input  logic [7:0]          note_y,
  output logic [X_W-1:0]      vga_x,
  output logic [Y_W-1:0]      vga_y,
  output logic [COLOUR_W-1:0] vga_colour,
  output logic                vga_plot,
  output logic                busy,
  output logic                done,
  output logic                overrun
);
  lane_state_t state, state_next;

  logic [7:0] new_y;
  logic [7:0] old_y;
  logic       old_valid;
  logic       sweep_start;
  logic [7:0] sweep_base;
  logic [3:0] dx;
  logic [8:0] dy;
  logic       last;
  logic       active;

  rect_sweep_counter #(
    .NOTE_W (NOTE_W),
    .NOTE_H (NOTE_H)
  ) u_sweep (
    .clk    (clk),
    .resetn (resetn),
    .start  (sweep_start),
    .base_y (sweep_base),
    .dx     (dx),
    .dy     (dy),
    .last   (last),
    .active (active)
  );

  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  // The erase sweep starts from IDLE on old_y; the draw sweep restarts on new_y at erase end
  always_comb begin
    state_next  = state;
    sweep_start = 1'b0;
    sweep_base  = (state == IDLE) ? old_y : new_y;
    unique case (state)
      IDLE: begin
        if (frame_tick) begin
          state_next  = ERASE;
          sweep_start = 1'b1;
        end
      end
      ERASE: begin
        if (last) begin
          state_next  = DRAW;
          sweep_start = 1'b1;
        end
      end
      DRAW: begin
        if (last) state_next = DONE;
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (state == IDLE && frame_tick) new_y <= note_y;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      old_y      <= '0;
      old_valid  <= 1'b0;
      done       <= 1'b0;
      overrun    <= 1'b0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      vga_plot   <= 1'b0;
    end else begin
      done <= (state == DONE);
      if (state == DONE) begin
        old_y     <= new_y;
        old_valid <= 1'b1;
      end
      if (frame_tick && state != IDLE) overrun <= 1'b1;
      // Clipped rows still consume their slot; only the strobe is withheld
      if (active && (state == ERASE || state == DRAW)) begin
        vga_x      <= LANE_X + {4'b0000, dx};
        vga_y      <= dy[Y_W-1:0];
        vga_colour <= (state == DRAW) ? NOTE_COLOUR : BG_COLOUR;
        vga_plot   <= (dy < 9'(SCREEN_H)) && (state == DRAW || old_valid);
      end else begin
        vga_plot <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_note_lane_renderer.sv
// Directed bench for note_lane_renderer with a per-slot pixel scoreboard.
module tb_note_lane_renderer;
  localparam int W = 8;
  localparam int H = 4;
  localparam int N = W * H;

  logic       clk = 1'b0;
  logic       resetn;
  logic       frame_tick;
  logic [7:0] note_y;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;
  logic       busy;
  logic       done;
  logic       overrun;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
    logic       p;
  } pix_t;

  pix_t q[$];
  int total = 0;
  int bad   = 0;
  logic [7:0] old_y_m;
  logic       old_valid_m;

  note_lane_renderer dut (
    .clk        (clk),
    .resetn     (resetn),
    .frame_tick (frame_tick),
    .note_y     (note_y),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot),
    .busy       (busy),
    .done       (done),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push_seq(input logic [7:0] ny);
    for (int i = 0; i < N; i++) begin
      int row;
      pix_t e;
      row = int'(old_y_m) + i / W;
      e.x = 8'(20 + i % W);
      e.y = 7'(row);
      e.c = 3'b000;
      e.p = old_valid_m && (row < 120);
      q.push_back(e);
    end
    for (int i = 0; i < N; i++) begin
      int row;
      pix_t e;
      row = int'(ny) + i / W;
      e.x = 8'(20 + i % W);
      e.y = 7'(row);
      e.c = 3'b110;
      e.p = (row < 120);
      q.push_back(e);
    end
  endtask

  // d1/d2: edge offsets from the accepted tick at which an extra tick is driven
  task automatic run_seq(input logic [7:0] ny, input int d1, input int d2);
    pix_t e;
    push_seq(ny);
    frame_tick = 1'b1;
    note_y     = ny;
    step();
    frame_tick = 1'b0;
    note_y     = 8'd50;
    chk("busy_start", busy, 1);
    chk("done_start", done, 0);
    chk("plot_start", vga_plot, 0);
    for (int j = 1; j <= 2 * N + 1; j++) begin
      frame_tick = (j == d1 || j == d2);
      step();
      frame_tick = 1'b0;
      if (j <= 2 * N) begin
        chk("busy_run", busy, 1);
        chk("done_run", done, 0);
        if (q.size() == 0) begin
          chk("sb_empty", 1, 0);
        end else begin
          e = q.pop_front();
          chk("plot", vga_plot, e.p);
          if (e.p) begin
            chk("x", vga_x, e.x);
            chk("y", vga_y, e.y);
            chk("colour", vga_colour, e.c);
          end
        end
      end else begin
        chk("done_end", done, 1);
        chk("busy_end", busy, 0);
        chk("plot_end", vga_plot, 0);
        chk("sb_drained", q.size(), 0);
      end
    end
    old_y_m     = ny;
    old_valid_m = 1'b1;
  endtask

  initial begin
    resetn     = 1'b0;
    frame_tick = 1'b0;
    note_y     = 8'd0;
    repeat (3) step();
    chk("rst_x", vga_x, 0);
    chk("rst_y", vga_y, 0);
    chk("rst_colour", vga_colour, 0);
    chk("rst_plot", vga_plot, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_overrun", overrun, 0);
    resetn      = 1'b1;
    old_y_m     = 8'd0;
    old_valid_m = 1'b0;
    step();

    run_seq(8'd10, -1, -1);
    run_seq(8'd14, -1, -1);
    run_seq(8'd118, -1, -1);
    chk("overrun_clear", overrun, 0);

    run_seq(8'd40, 10, 2 * N + 1);
    chk("overrun_set", overrun, 1);
    run_seq(8'd60, -1, -1);
    chk("overrun_sticky", overrun, 1);

    frame_tick = 1'b1;
    note_y     = 8'd70;
    step();
    frame_tick = 1'b0;
    repeat (39) step();
    resetn = 1'b0;
    step();
    chk("abort_x", vga_x, 0);
    chk("abort_y", vga_y, 0);
    chk("abort_colour", vga_colour, 0);
    chk("abort_plot", vga_plot, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_overrun", overrun, 0);
    resetn      = 1'b1;
    old_y_m     = 8'd0;
    old_valid_m = 1'b0;
    q.delete();
    run_seq(8'd30, -1, -1);

    run_seq(8'd255, -1, -1);
    run_seq(8'd5, -1, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
